// File: rtl/spi_master_gen.sv
// spi_master_gen: parametrised full-duplex SPI master.
//
// A host-side start/done handshake launches one DATA_W-bit transfer. SPI mode
// (cpol/cpha), bit order and target slave are chosen per transfer and latched
// when the transfer is accepted. SCLK is generated from clk, with CLK_DIV clk
// cycles per SCLK half-period.
//
// Ports:
//   clk, rst       system clock (rising edge), synchronous active-high reset
//   start          transfer request, accepted only while idle
//   tx_data        word to transmit, latched at acceptance
//   ss_sel         slave index, latched at acceptance (out of range -> no select)
//   cpol, cpha     SPI mode, latched at acceptance (cpol also sets idle SCLK)
//   lsb_first      1: bit 0 travels first on both mosi and miso
//   busy           high from acceptance until done
//   done           one-cycle pulse at the end of a transfer
//   rx_data        received word, updated together with done
//   sclk, mosi     SPI clock and serial data out
//   miso           SPI serial data in
//   ss_n           one-hot active-low slave selects
module spi_master_gen #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned NUM_SS  = 1,
    parameter int unsigned SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [DATA_W-1:0]   tx_sh;
    logic [DATA_W-1:0]   rx_sh;
    logic                cpol_q;
    logic                cpha_q;
    logic                lsb_q;

    logic                tick_c;
    logic                leading_c;
    logic                sample_c;
    logic                shift_c;
    logic                tx_bit_c;
    logic [DATA_W-1:0]   rx_next_c;

    // Decode the slave index; an out-of-range index selects nobody.
    function automatic logic [NUM_SS-1:0] decode_ss(input logic [SEL_W-1:0] sel);
        logic [NUM_SS-1:0] r;
        r = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (sel == SEL_W'(i)) begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    // Bit that leaves first for the chosen order.
    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    // Move the next bit into the outgoing position.
    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // Edge timing and per-edge actions. edge_cnt holds k-1 for the edge that
    // the next tick produces, so k is odd (leading) when edge_cnt is even.
    always_comb begin
        tick_c    = (div_cnt == DIV_W'(CLK_DIV - 1));
        leading_c = ~edge_cnt[0];
        sample_c  = 1'b0;
        shift_c   = 1'b0;
        if (cpha_q) begin
            sample_c = ~leading_c;
            shift_c  = leading_c;
        end else begin
            sample_c = leading_c;
            // mosi already carries bit 0, so only trailing edges 2..2*DATA_W-2 advance
            shift_c  = ~leading_c && (edge_cnt <= EDGE_W'(2 * DATA_W - 3));
        end
        tx_bit_c  = first_bit(tx_sh, lsb_q);
        rx_next_c = lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
    end

    // Transfer sequencer with registered SPI pins and host handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sclk     <= cpol;
                    mosi     <= 1'b0;
                    ss_n     <= '1;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    if (start) begin
                        cpol_q <= cpol;
                        cpha_q <= cpha;
                        lsb_q  <= lsb_first;
                        busy   <= 1'b1;
                        ss_n   <= decode_ss(ss_sel);
                        rx_sh  <= '0;
                        // CPHA=0 presents bit 0 immediately; CPHA=1 waits for edge 1.
                        if (cpha) begin
                            mosi  <= 1'b0;
                            tx_sh <= tx_data;
                        end else begin
                            mosi  <= first_bit(tx_data, lsb_first);
                            tx_sh <= advance(tx_data, lsb_first);
                        end
                        state <= SETUP;
                    end
                end

                SETUP, XFER: begin
                    div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
                    if (tick_c) begin
                        edge_cnt <= edge_cnt + EDGE_W'(1);
                        sclk     <= ~sclk;
                        if (sample_c) begin
                            rx_sh <= rx_next_c;
                        end
                        if (shift_c) begin
                            mosi  <= tx_bit_c;
                            tx_sh <= advance(tx_sh, lsb_q);
                        end
                        if (state == SETUP) begin
                            state <= XFER;
                        end else if (edge_cnt == EDGE_W'(2 * DATA_W - 1)) begin
                            state <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    // Last bit stays on mosi for one half-period with SCLK at rest.
                    sclk    <= cpol_q;
                    div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
                    if (tick_c) begin
                        ss_n     <= '1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rx_data  <= rx_sh;
                        mosi     <= 1'b0;
                        edge_cnt <= '0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: two instances (8-bit/div 2/4 selects with a mode-aware
// SPI slave model, and 16-bit/div 1/3 selects in loopback). Stimulus pushes the
// expected result of each transfer into a queue; monitors pop and compare on done.
module tb_spi_master_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic pick(input logic [15:0] w, input int i, input int width, input logic lsb);
        int j;
        j = lsb ? i : (width - 1 - i);
        return w[j[3:0]];
    endfunction

    typedef struct {
        logic [15:0] rx;
        logic [15:0] tx;
        logic [3:0]  ss;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // ---------------- instance A: DATA_W=8, CLK_DIV=2, NUM_SS=4
    logic       rst_a = 1'b1, start_a = 1'b0, cpol_a = 1'b0, cpha_a = 1'b0, lsb_a = 1'b0;
    logic [7:0] tx_a = '0;
    logic [1:0] sel_a = '0;
    logic       busy_a, done_a, sclk_a, mosi_a;
    logic       miso_a = 1'b0;
    logic [7:0] rx_a;
    logic [3:0] ssn_a;

    spi_master_gen #(.DATA_W(8), .CLK_DIV(2), .NUM_SS(4)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .tx_data(tx_a), .ss_sel(sel_a),
        .cpol(cpol_a), .cpha(cpha_a), .lsb_first(lsb_a), .busy(busy_a), .done(done_a),
        .rx_data(rx_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .ss_n(ssn_a)
    );

    // ---------------- instance B: DATA_W=16, CLK_DIV=1, NUM_SS=3, miso looped to mosi
    logic        rst_b = 1'b1, start_b = 1'b0, cpol_b = 1'b0, cpha_b = 1'b0, lsb_b = 1'b0;
    logic [15:0] tx_b = '0;
    logic [1:0]  sel_b = '0;
    logic        busy_b, done_b, sclk_b, mosi_b, miso_b;
    logic [15:0] rx_b;
    logic [2:0]  ssn_b;

    assign miso_b = mosi_b;

    spi_master_gen #(.DATA_W(16), .CLK_DIV(1), .NUM_SS(3)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .tx_data(tx_b), .ss_sel(sel_b),
        .cpol(cpol_b), .cpha(cpha_b), .lsb_first(lsb_b), .busy(busy_b), .done(done_b),
        .rx_data(rx_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .ss_n(ssn_b)
    );

    // ---------------- monitor + slave model for A
    int       cyc_a = 0, t0_a = 0, last_done_a = 0, gap_a = 0, dones_a = 0, rises_a = 0;
    logic     busy_prev_a = 1'b0, sclk_prev_a = 1'b0, ss_err_a = 1'b0;
    logic     s_on = 1'b0;
    int       s_cnt = 0, s_idx = 0;
    logic [7:0] s_cap = '0, s_word_a = '0;

    always @(posedge clk) begin
        exp_t e;
        logic lead;
        #1;
        cyc_a++;
        if (busy_a && !busy_prev_a) begin
            t0_a     = cyc_a;
            gap_a    = cyc_a - last_done_a;
            rises_a  = 0;
            ss_err_a = 1'b0;
        end
        if (busy_a && q_a.size() > 0 && ssn_a !== q_a[0].ss) ss_err_a = 1'b1;
        if (done_a) begin
            dones_a++;
            last_done_a = cyc_a;
            if (q_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_spurious_done: got done at cycle %0d, expected none", cyc_a);
            end else begin
                e = q_a.pop_front();
                check("a_rx_data", 32'(rx_a), 32'(e.rx[7:0]));
                check("a_mosi_word", 32'(s_cap), 32'(e.tx[7:0]));
                check("a_latency", 32'(cyc_a - t0_a), 32'd34);
                check("a_ss_n_during", 32'(ss_err_a), 32'd0);
                check("a_sclk_rises", 32'(rises_a), 32'd8);
            end
        end
        busy_prev_a = busy_a;

        // SPI slave: shifts s_word_a out on miso and captures mosi.
        if (ssn_a == 4'hF) begin
            s_on   = 1'b0;
            miso_a = 1'b0;
        end else if (!s_on) begin
            s_on  = 1'b1;
            s_cnt = 0;
            s_cap = '0;
            s_idx = 0;
            if (!cpha_a) begin
                miso_a = pick({8'h00, s_word_a}, 0, 8, lsb_a);
                s_idx  = 1;
            end
        end else if (sclk_a != sclk_prev_a) begin
            lead = (sclk_prev_a == cpol_a);
            if (sclk_a) rises_a++;
            if (lead ^ cpha_a) begin
                if (s_cnt < 8) begin
                    if (lsb_a) s_cap[s_cnt[2:0]] = mosi_a;
                    else       s_cap[3'(7 - s_cnt)] = mosi_a;
                end
                s_cnt++;
            end else if (s_idx < 8) begin
                miso_a = pick({8'h00, s_word_a}, s_idx, 8, lsb_a);
                s_idx++;
            end
        end
        sclk_prev_a = sclk_a;
    end

    // ---------------- monitor for B
    int   cyc_b = 0, t0_b = 0, dones_b = 0, rises_b = 0;
    logic busy_prev_b = 1'b0, sclk_prev_b = 1'b0, ss_err_b = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc_b++;
        if (busy_b && !busy_prev_b) begin
            t0_b     = cyc_b;
            rises_b  = 0;
            ss_err_b = 1'b0;
        end
        if (busy_b && busy_prev_b && sclk_b && !sclk_prev_b) rises_b++;
        if (busy_b && q_b.size() > 0 && ssn_b !== q_b[0].ss[2:0]) ss_err_b = 1'b1;
        if (done_b) begin
            dones_b++;
            if (q_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_spurious_done: got done at cycle %0d, expected none", cyc_b);
            end else begin
                e = q_b.pop_front();
                check("b_rx_data", 32'(rx_b), 32'(e.rx));
                check("b_latency", 32'(cyc_b - t0_b), 32'd33);
                check("b_ss_n_during", 32'(ss_err_b), 32'd0);
                check("b_sclk_rises", 32'(rises_b), 32'd16);
            end
        end
        busy_prev_b = busy_b;
        sclk_prev_b = sclk_b;
    end

    // ---------------- stimulus helpers
    task automatic go_a(input logic [7:0] tx, input logic [7:0] sw, input logic [1:0] sel,
                        input logic [3:0] ss, input logic pol, input logic pha, input logic lsb);
        exp_t e;
        e.rx = {8'h00, sw};
        e.tx = {8'h00, tx};
        e.ss = ss;
        q_a.push_back(e);
        @(negedge clk);
        s_word_a = sw; tx_a = tx; sel_a = sel;
        cpol_a = pol; cpha_a = pha; lsb_a = lsb;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic go_b(input logic [15:0] tx, input logic [1:0] sel, input logic [2:0] ss,
                        input logic pol, input logic pha, input logic lsb);
        exp_t e;
        e.rx = tx;
        e.tx = tx;
        e.ss = {1'b0, ss};
        q_b.push_back(e);
        @(negedge clk);
        tx_b = tx; sel_b = sel; cpol_b = pol; cpha_b = pha; lsb_b = lsb;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic wait_dones_a(input int target);
        int n = 0;
        while (dones_a < target && n < 400) begin
            @(posedge clk); #2; n++;
        end
        check("a_done_arrived", 32'(dones_a >= target), 32'd1);
    endtask

    task automatic wait_dones_b(input int target);
        int n = 0;
        while (dones_b < target && n < 400) begin
            @(posedge clk); #2; n++;
        end
        check("b_done_arrived", 32'(dones_b >= target), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        exp_t e;

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_rx", 32'(rx_a), 32'd0);
        check("rst_sclk", 32'(sclk_a), 32'd0);
        check("rst_mosi", 32'(mosi_a), 32'd0);
        check("rst_ss_n", 32'(ssn_a), 32'hF);
        check("rst_ss_n_b", 32'(ssn_b), 32'h7);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);

        // Mode 0, MSB first, slave 2
        go_a(8'hA5, 8'h3C, 2'd2, 4'b1011, 1'b0, 1'b0, 1'b0);
        wait_dones_a(1);

        // Mode 3, LSB first: SCLK idles high before and after
        @(negedge clk);
        cpol_a = 1'b1;
        @(posedge clk); #2;
        check("a_idle_sclk_cpol1", 32'(sclk_a), 32'd1);
        go_a(8'h81, 8'h7E, 2'd0, 4'b1110, 1'b1, 1'b1, 1'b1);
        wait_dones_a(2);
        @(posedge clk); #2;
        check("a_idle_sclk_after_mode3", 32'(sclk_a), 32'd1);

        // Back-to-back with start held high; tx change mid-transfer must not leak in
        e.rx = 16'h005A; e.tx = 16'h0011; e.ss = 4'b1101; q_a.push_back(e);
        e.rx = 16'h005A; e.tx = 16'h0022; e.ss = 4'b1101; q_a.push_back(e);
        @(negedge clk);
        s_word_a = 8'h5A; tx_a = 8'h11; sel_a = 2'd1;
        cpol_a = 1'b0; cpha_a = 1'b0; lsb_a = 1'b0;
        start_a = 1'b1;
        repeat (6) @(negedge clk);
        tx_a = 8'h22;
        wait_dones_a(3);
        check("a_b2b_ss_high", 32'(ssn_a), 32'hF);
        @(posedge clk); #2;
        check("a_b2b_ss_reselect", 32'(ssn_a), 32'b1101);
        @(negedge clk);
        start_a = 1'b0;
        wait_dones_a(4);
        check("a_b2b_gap", 32'(gap_a), 32'd1);
        repeat (40) @(posedge clk); #2;
        check("a_b2b_done_count", 32'(dones_a), 32'd4);

        // Reset in the middle of a transfer
        e.rx = 16'h0000; e.tx = 16'h0000; e.ss = 4'b1110; q_a.push_back(e);
        @(negedge clk);
        tx_a = 8'hF0; sel_a = 2'd0; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk); #2;
        check("a_abort_busy", 32'(busy_a), 32'd0);
        check("a_abort_ss_n", 32'(ssn_a), 32'hF);
        check("a_abort_sclk", 32'(sclk_a), 32'd0);
        check("a_abort_done", 32'(done_a), 32'd0);
        q_a.delete();
        d0 = dones_a;
        @(negedge clk);
        rst_a = 1'b0;
        repeat (40) @(posedge clk); #2;
        check("a_abort_no_done", 32'(dones_a), 32'(d0));

        // Transfer after the abort, mode 1
        go_a(8'hC3, 8'h96, 2'd3, 4'b0111, 1'b0, 1'b1, 1'b0);
        wait_dones_a(d0 + 1);

        // 16-bit loopback in all four modes, plus LSB-first
        go_b(16'hBEEF, 2'd1, 3'b101, 1'b0, 1'b0, 1'b0); wait_dones_b(1);
        go_b(16'hBEEF, 2'd1, 3'b101, 1'b0, 1'b1, 1'b0); wait_dones_b(2);
        go_b(16'hBEEF, 2'd1, 3'b101, 1'b1, 1'b0, 1'b0); wait_dones_b(3);
        go_b(16'hBEEF, 2'd1, 3'b101, 1'b1, 1'b1, 1'b0); wait_dones_b(4);
        go_b(16'hBEEF, 2'd0, 3'b110, 1'b0, 1'b1, 1'b1); wait_dones_b(5);

        // Out-of-range select: no ss_n asserts, transfer still completes
        go_b(16'h1234, 2'd3, 3'b111, 1'b0, 1'b0, 1'b0); wait_dones_b(6);

        repeat (5) @(posedge clk); #2;
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
Parametrised, full-duplex SPI master. It supersedes the fixed 8-bit, transmit-only, single-select SPI master with a generated SCLK, runtime-selectable SPI mode (CPOL/CPHA), MSB/LSB-first ordering, MISO capture and NUM_SS one-hot slave selects. It sits between a host-side start/done handshake and off-chip SPI pins.

Parameters:
DATA_W, 8, bits per transfer (>=2)
CLK_DIV, 2, clk cycles per SCLK half-period (>=1)
NUM_SS, 1, number of active-low slave-select lines (>=1)
SEL_W, (NUM_SS>1 ? $clog2(NUM_SS) : 1), width of ss_sel

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  transfer request; accepted only in IDLE
tx_data  input  DATA_W  word to transmit; latched at acceptance
ss_sel  input  SEL_W  slave index; latched at acceptance
cpol  input  1  SCLK idle level; latched at acceptance
cpha  input  1  0: sample on leading edge; 1: sample on trailing edge
lsb_first  input  1  1: bit 0 shifted first; latched at acceptance
busy  output  1  high from acceptance until done
done  output  1  one-cycle pulse at transfer end
rx_data  output  DATA_W  received word; valid from done, held until next done
sclk  output  1  SPI clock
mosi  output  1  serial data out
miso  input  1  serial data in
ss_n  output  NUM_SS  active-low selects

Behaviour:
- Reset: busy=0, done=0, rx_data=0, sclk=0, mosi=0, ss_n=all 1, state=IDLE, counters cleared. A reset during a transfer aborts it immediately, with no done pulse.
- States: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
- IDLE:
  - sclk <= cpol (live input) every cycle; mosi=0; ss_n all 1.
  - When start=1 on clock edge T0, latch tx_data, ss_sel, cpol, cpha and lsb_first.
  - At T0: busy<=1, ss_n[ss_sel]<=0, enter SETUP.
- Out-of-range ss_sel: if ss_sel>=NUM_SS, no ss_n bit asserts, but the transfer still runs to completion.
- start while busy is ignored; it is neither queued nor able to corrupt the latched configuration.
- Edge timing: SCLK edge k (k=1..2*DATA_W) toggles sclk at T0+k*CLK_DIV. Odd k are leading edges; even k are trailing edges.
- Bit order: lsb_first=0 sends/receives MSB first; lsb_first=1 sends/receives LSB first. The same order applies to tx and rx.
- CPHA=0:
  - First bit is on mosi at T0.
  - miso is sampled at leading edges.
  - mosi advances at trailing edges k=2..2*DATA_W-2.
- CPHA=1:
  - mosi advances at each leading edge; the first bit appears at edge 1.
  - miso is sampled at trailing edges.
- Sampling: each sample captures miso as present at that clk edge. Exactly DATA_W samples are taken per transfer.
- HOLD: after edge 2*DATA_W, sclk rests at latched cpol. mosi holds the last bit for CLK_DIV cycles.
- End of transfer, at T0+(2*DATA_W+1)*CLK_DIV:
  - ss_n <= all 1, busy <= 0, done <= 1, rx_data updated, mosi <= 0, return to IDLE.
- done lasts exactly one cycle.
- Back-to-back: start may be accepted in the cycle done is high. ss_n then stays high for exactly 1 clk cycle between transfers.
- Latency: start acceptance to done = (2*DATA_W+1)*CLK_DIV cycles.
- Counter widths: half-period counter covers 0..CLK_DIV-1; edge counter covers 0..2*DATA_W. No wrap-around inside a transfer.

Test Plan:
- Mode 0, MSB-first: DATA_W=8, CLK_DIV=2; start, tx_data=0xA5, miso driven from slave model 0x3C -> MSB-first on mosi 1,0,1,0,0,1,0,1 stable at rising sclk; done at T0+34; rx_data=0x3C; exactly 8 rising sclk edges; ss_n low T0..T0+34.
- Mode 3, LSB-first: cpol=1, cpha=1, lsb_first=1, tx=0x81, slave 0x7E -> sclk idles high; mosi bits 1,0,0,0,0,0,0,1 change on falling edges; rx_data=0x7E.
- Multi-slave: NUM_SS=4, ss_sel=2 -> ss_n=4'b1011 during transfer; ss_sel=5 (SEL_W=2 caps at 3, so use NUM_SS=3, ss_sel=3) -> ss_n stays all 1, done still pulses.
- Back-to-back and busy ignore: start held high across two transfers with tx 0x11 then 0x22; second start pulse mid-transfer -> exactly two done pulses; ss_n high exactly 1 cycle between them; second transfer sends 0x22.
- Reset mid-transfer: assert rst at T0+10 -> next cycle ss_n all 1, busy=0, sclk=0, no done pulse; a new transfer afterwards completes normally.
- Parameter sweep: DATA_W=16, CLK_DIV=1, tx 0xBEEF loopback (miso=mosi) -> rx_data=0xBEEF in all four modes; done at T0+33.
